// File: rtl/cpu_opponent.sv
// rtl/cpu_opponent.sv - computer-controlled fighter producing one-hot actions per game step
//
// Purpose: replaces a human input for one player slot. Once per enabled tick
// it picks an action with a priority FSM, an attack-streak counter and a
// 4-bit LFSR that occasionally makes the fighter hesitate.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   enable             CPU control active; low forces IDLE / NONE
//   tick               one-cycle game-step strobe
//   self_location      own location 0..2 (0 = closest to centre)
//   opp_location       opponent location 0..2
//   self_health        own health 0..3
//   opp_health         opponent health 0..3
//   opp_action         opponent's previous one-hot action
//   action             registered one-hot action code
//   action_valid       one-cycle pulse when action updates
//   state              FSM state (debug / HUD)

module cpu_opponent #(
  parameter bit         SIDE       = 1'b0,
  parameter logic [3:0] SEED       = 4'h1,
  parameter int         MAX_STREAK = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       tick,
  input  logic [1:0] self_location,
  input  logic [1:0] opp_location,
  input  logic [1:0] self_health,
  input  logic [1:0] opp_health,
  input  logic [5:0] opp_action,
  output logic [5:0] action,
  output logic       action_valid,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_APPROACH = 3'd1,
    S_ATTACK   = 3'd2,
    S_DEFEND   = 3'd3,
    S_RECOVER  = 3'd4,
    S_RETREAT  = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  localparam logic [5:0] A_GO_RIGHT = 6'b100000;
  localparam logic [5:0] A_GO_LEFT  = 6'b010000;
  localparam logic [5:0] A_WAIT     = 6'b001000;
  localparam logic [5:0] A_JUMP     = 6'b000100;
  localparam logic [5:0] A_KICK     = 6'b000010;
  localparam logic [5:0] A_PUNCH    = 6'b000001;
  localparam logic [5:0] A_NONE     = 6'b000000;

  localparam logic [5:0] A_ADVANCE = SIDE ? A_GO_LEFT  : A_GO_RIGHT;
  localparam logic [5:0] A_RETREAT = SIDE ? A_GO_RIGHT : A_GO_LEFT;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [3:0] LFSR_INIT  = (SEED == 4'h0) ? 4'h1 : SEED;
  localparam logic [2:0] STREAK_MAX = MAX_STREAK[2:0];

  state_t     st;
  logic [5:0] action_r;
  logic       valid_r;
  logic [2:0] streak;
  logic [3:0] lfsr;

  logic [2:0] distance;
  logic       opp_attacking;
  logic [2:0] streak_inc;

  assign distance      = {1'b0, self_location} + {1'b0, opp_location};
  // Non-one-hot codes never match these two, so they count as non-attacks.
  assign opp_attacking = (opp_action == A_KICK) || (opp_action == A_PUNCH);
  assign streak_inc    = streak + 3'd1;

  assign action       = action_r;
  assign action_valid = valid_r;
  assign state        = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      action_r <= A_NONE;
      valid_r  <= 1'b0;
      streak   <= 3'd0;
      lfsr     <= LFSR_INIT;
    end else if (!enable) begin
      // LFSR is deliberately left untouched while disabled.
      st       <= S_IDLE;
      action_r <= A_NONE;
      valid_r  <= 1'b0;
      streak   <= 3'd0;
    end else if (st == S_HALT) begin
      // Absorbing: only reset or enable low leave HALT.
      valid_r <= 1'b0;
    end else if (tick) begin
      valid_r <= 1'b1;
      lfsr    <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      streak  <= 3'd0;
      if (self_health == 2'd0 || opp_health == 2'd0) begin
        st       <= S_HALT;
        action_r <= A_NONE;
      end else if (opp_attacking && distance <= 3'd1) begin
        st       <= S_DEFEND;
        action_r <= A_JUMP;
      end else if (self_health == 2'd1 && distance >= 3'd2) begin
        st       <= S_RECOVER;
        action_r <= A_WAIT;
      end else if (distance <= 3'd1) begin
        if (streak_inc == STREAK_MAX) begin
          st       <= S_RETREAT;
          // Already at the back wall: cannot retreat further.
          action_r <= (self_location == 2'd2) ? A_WAIT : A_RETREAT;
        end else begin
          st       <= S_ATTACK;
          action_r <= (distance == 3'd0) ? A_PUNCH : A_KICK;
          streak   <= streak_inc;
        end
      end else if (lfsr == 4'hF) begin
        // Hesitation uses the LFSR value before this tick's advance.
        st       <= S_IDLE;
        action_r <= A_WAIT;
      end else begin
        st       <= S_APPROACH;
        action_r <= A_ADVANCE;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_opponent.sv
// tb/tb_cpu_opponent.sv - self-checking bench for cpu_opponent with reference model

module tb_cpu_opponent;

  localparam logic [5:0] GO_RIGHT = 6'b100000;
  localparam logic [5:0] GO_LEFT  = 6'b010000;
  localparam logic [5:0] WAIT_A   = 6'b001000;
  localparam logic [5:0] JUMP     = 6'b000100;
  localparam logic [5:0] KICK     = 6'b000010;
  localparam logic [5:0] PUNCH    = 6'b000001;
  localparam logic [5:0] NONE     = 6'b000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] self_location = 2'd0;
  logic [1:0] opp_location = 2'd0;
  logic [1:0] self_health = 2'd3;
  logic [1:0] opp_health = 2'd3;
  logic [5:0] opp_action = 6'b001000;
  logic [5:0] action;
  logic       action_valid;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [5:0] m_act;
  logic       m_val;
  int         m_st;
  int         m_streak;
  int         m_lfsr;

  cpu_opponent #(.SIDE(1'b0), .SEED(4'h1), .MAX_STREAK(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
    .self_location(self_location), .opp_location(opp_location),
    .self_health(self_health), .opp_health(opp_health),
    .opp_action(opp_action), .action(action),
    .action_valid(action_valid), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Behavioural rules evaluated on each clock edge from the sampled inputs.
  task automatic model_edge();
    int d;
    bit atk;
    d   = int'(self_location) + int'(opp_location);
    atk = (opp_action == KICK) || (opp_action == PUNCH);
    if (!rst_n) begin
      m_act = NONE; m_val = 0; m_st = 0; m_streak = 0; m_lfsr = 1;
    end else if (!enable) begin
      m_act = NONE; m_val = 0; m_st = 0; m_streak = 0;
    end else if (m_st == 6) begin
      m_val = 0;
    end else if (tick) begin
      m_val = 1;
      if (self_health == 0 || opp_health == 0) begin
        m_st = 6; m_act = NONE; m_streak = 0;
      end else if (atk && d <= 1) begin
        m_st = 3; m_act = JUMP; m_streak = 0;
      end else if (self_health == 1 && d >= 2) begin
        m_st = 4; m_act = WAIT_A; m_streak = 0;
      end else if (d <= 1) begin
        if (m_streak + 1 == 3) begin
          m_st = 5; m_act = (self_location == 2) ? WAIT_A : GO_LEFT; m_streak = 0;
        end else begin
          m_st = 2; m_act = (d == 0) ? PUNCH : KICK; m_streak = m_streak + 1;
        end
      end else if (m_lfsr == 15) begin
        m_st = 0; m_act = WAIT_A; m_streak = 0;
      end else begin
        m_st = 1; m_act = GO_RIGHT; m_streak = 0;
      end
      m_lfsr = ((m_lfsr << 1) & 15) | (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
    end else begin
      m_val = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("action", int'(action), int'(m_act));
    check("valid", int'(action_valid), int'(m_val));
    check("state", int'(state), m_st);
  endtask

  task automatic set_in(input int sl, input int ol, input int sh, input int oh, input logic [5:0] oa);
    self_location = 2'(sl); opp_location = 2'(ol);
    self_health = 2'(sh); opp_health = 2'(oh); opp_action = oa;
  endtask

  // One tick edge; the caller checks the result, then a quiet edge checks hold.
  task automatic do_tick(input string tag, input logic [5:0] exp_act, input int exp_st);
    tick = 1'b1;
    step();
    check({tag, "_act"}, int'(action), int'(exp_act));
    check({tag, "_st"}, int'(state), exp_st);
    check({tag, "_vld"}, int'(action_valid), 1);
    tick = 1'b0;
    step();
    check({tag, "_hold"}, int'(action), int'(exp_act));
    check({tag, "_vld0"}, int'(action_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    check("rst_act", int'(action), 0);
    check("rst_st", int'(state), 0);
    rst_n = 1'b1;
    enable = 1'b1;

    set_in(2, 2, 3, 3, WAIT_A);
    do_tick("approach", GO_RIGHT, 1);

    set_in(0, 0, 3, 3, WAIT_A);
    do_tick("punch1", PUNCH, 2);
    do_tick("punch2", PUNCH, 2);
    do_tick("retreat", GO_LEFT, 5);
    do_tick("punch3", PUNCH, 2);

    set_in(1, 0, 3, 3, KICK);
    do_tick("defend", JUMP, 3);
    set_in(1, 0, 3, 3, WAIT_A);
    do_tick("kick", KICK, 2);

    set_in(2, 1, 1, 3, WAIT_A);
    do_tick("recover1", WAIT_A, 4);
    do_tick("recover2", WAIT_A, 4);
    set_in(2, 1, 3, 3, WAIT_A);
    do_tick("resume", GO_RIGHT, 1);

    // Fresh LFSR, 12 back-to-back ticks at distance 4.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_in(2, 2, 3, 3, WAIT_A);
    tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("lfsr_act", int'(action), (i < 11) ? int'(GO_RIGHT) : int'(WAIT_A));
      check("lfsr_vld", int'(action_valid), 1);
    end
    check("lfsr_idle", int'(state), 0);
    tick = 1'b0;
    step();

    set_in(2, 2, 3, 0, WAIT_A);
    do_tick("halt", NONE, 6);
    set_in(0, 0, 3, 3, WAIT_A);
    tick = 1'b1;
    step();
    check("halt_keep", int'(state), 6);
    check("halt_novld", int'(action_valid), 0);
    tick = 1'b0;
    enable = 1'b0;
    step();
    check("dis_st", int'(state), 0);
    enable = 1'b1;

    do_tick("ms1", PUNCH, 2);
    do_tick("ms2", PUNCH, 2);
    rst_n = 1'b0;
    step();
    check("ms_rst_act", int'(action), 0);
    check("ms_rst_st", int'(state), 0);
    rst_n = 1'b1;
    do_tick("ms_after", PUNCH, 2);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 99) >= 2);
      enable = ($urandom_range(0, 99) >= 6);
      tick   = $urandom_range(0, 1) == 1;
      self_location = 2'($urandom_range(0, 2));
      opp_location  = 2'($urandom_range(0, 2));
      self_health   = ($urandom_range(0, 19) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      opp_health    = ($urandom_range(0, 19) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      case ($urandom_range(0, 4))
        0: opp_action = KICK;
        1: opp_action = PUNCH;
        2: opp_action = 6'($urandom);
        default: opp_action = WAIT_A;
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
